// File: rtl/spi_slave_rx_if.sv
// SPI receive bus bundle: serial lines from the transmitter plus the word-level
// results handed to the consumer.
interface spi_slave_rx_if #(
   parameter int DATA_W = 16
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   logic              spi_cs;
   logic              spi_sclk;
   logic              spi_data;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              frame_err;
   logic [CNT_W-1:0]  bit_count;

   modport master (
      output spi_cs, spi_sclk, spi_data,
      input  data_out, data_valid, frame_err, bit_count
   );

   modport slave (
      input  spi_cs, spi_sclk, spi_data,
      output data_out, data_valid, frame_err, bit_count
   );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampling SPI receiver: MSB-first words, data_valid SYNC_STAGES+1 clk after the last sclk rise.
// No backpressure: each completed word overwrites data_out whether or not it was consumed.
module spi_slave_rx #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int CS_PER_WORD = 0
) (
   input  logic          clk,
   input  logic          rst,
   spi_slave_rx_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   cs_q;
   logic                   sclk_q;
   logic [DATA_W-1:0]      shift_reg;
   logic [DATA_W-1:0]      data_out;
   logic                   data_valid;
   logic                   frame_err;
   logic [CNT_W-1:0]       bit_count;

   logic                   cs_s;
   logic                   sclk_s;
   logic                   data_s;
   logic                   rise_evt;
   logic                   cs_rise;
   logic                   last_bit;
   logic [DATA_W-1:0]      shift_nxt;

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign data_s    = data_sync[SYNC_STAGES-1];

   // Sampling is gated by the synced cs of the same cycle, so a bit that
   // coincides with cs going high is dropped.
   assign rise_evt  = sclk_s & ~sclk_q & ~cs_s;
   assign cs_rise   = cs_s & ~cs_q;
   assign shift_nxt = {shift_reg[DATA_W-2:0], data_s};
   assign last_bit  = (bit_count == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync    <= '1;
         sclk_sync  <= '0;
         data_sync  <= '0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
         shift_reg  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         bit_count  <= '0;
         state      <= IDLE;
      end else begin
         cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         data_sync  <= {data_sync[SYNC_STAGES-2:0], bus.spi_data};
         cs_q       <= cs_s;
         sclk_q     <= sclk_s;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;

         case (state)
            IDLE: begin
               if (rise_evt) begin
                  shift_reg <= shift_nxt;
                  bit_count <= CNT_W'(1);
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               // With CS_PER_WORD=0 a cs-high gap just pauses the word.
               if ((CS_PER_WORD != 0) && cs_rise) begin
                  frame_err <= 1'b1;
                  bit_count <= '0;
                  state     <= IDLE;
               end else if (rise_evt) begin
                  shift_reg <= shift_nxt;
                  if (last_bit) begin
                     data_out   <= shift_nxt;
                     data_valid <= 1'b1;
                     bit_count  <= '0;
                     state      <= IDLE;
                  end else begin
                     bit_count  <= bit_count + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_out   = data_out;
   assign bus.data_valid = data_valid;
   assign bus.frame_err  = frame_err;
   assign bus.bit_count  = bit_count;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Drives two receivers (cs-gap tolerant and cs-per-word) from one SPI stimulus
// and scores them against a bit-level reference model.
module tb_spi_slave_rx;
   localparam int DW   = 16;
   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1;

   logic clk = 1'b0;
   logic rst;
   logic cs;
   logic sclk;
   logic sd;

   always #5 clk = ~clk;

   spi_slave_rx_if #(.DATA_W(DW)) bus0 ();
   spi_slave_rx_if #(.DATA_W(DW)) bus1 ();

   assign bus0.spi_cs   = cs;
   assign bus0.spi_sclk = sclk;
   assign bus0.spi_data = sd;
   assign bus1.spi_cs   = cs;
   assign bus1.spi_sclk = sclk;
   assign bus1.spi_data = sd;

   spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC), .CS_PER_WORD(0)) u0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));
   spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC), .CS_PER_WORD(1)) u1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rise_cyc = 0;
   int err_exp1 = 0;
   int err_seen0 = 0;
   int err_seen1 = 0;
   logic vld_prev0 = 1'b0;
   logic vld_prev1 = 1'b0;

   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   logic [DW-1:0] m_sh[2];
   int            m_cnt[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.data_valid) begin
            automatic int n = exp_q0.size();
            check("vld0_width", {31'd0, vld_prev0}, 0);
            check("vld0_latency", cyc - rise_cyc, LAT);
            check("vld0_pending", {31'd0, n > 0}, 1);
            if (n > 0) check("word0", {16'd0, bus0.data_out}, {16'd0, exp_q0.pop_front()});
         end
         if (bus1.data_valid) begin
            automatic int n = exp_q1.size();
            check("vld1_width", {31'd0, vld_prev1}, 0);
            check("vld1_latency", cyc - rise_cyc, LAT);
            check("vld1_pending", {31'd0, n > 0}, 1);
            if (n > 0) check("word1", {16'd0, bus1.data_out}, {16'd0, exp_q1.pop_front()});
         end
         if (bus0.frame_err) err_seen0++;
         if (bus1.frame_err) err_seen1++;
      end
      vld_prev0 <= bus0.data_valid;
      vld_prev1 <= bus1.data_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_sh[i]  = '0;
         m_cnt[i] = 0;
      end
   endtask

   // One sclk period, 4 clk low then 4 clk high; cs is assumed low.
   task automatic send_bit(input logic b);
      sd = b;
      tick(4);
      sclk = 1'b1;
      rise_cyc = cyc;
      for (int i = 0; i < 2; i++) begin
         m_sh[i] = {m_sh[i][DW-2:0], b};
         m_cnt[i]++;
         if (m_cnt[i] == DW) begin
            if (i == 0) exp_q0.push_back(m_sh[i]);
            else        exp_q1.push_back(m_sh[i]);
            m_cnt[i] = 0;
         end
      end
      tick(4);
      sclk = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      for (int i = DW - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic cs_up();
      tick(2);
      cs = 1'b1;
      if (m_cnt[1] != 0) begin
         err_exp1++;
         m_cnt[1] = 0;
      end
      tick(4);
   endtask

   task automatic cs_down();
      cs = 1'b0;
      tick(4);
   endtask

   task automatic end_test(input string tag);
      tick(8);
      check({tag, "_cnt0"}, {27'd0, bus0.bit_count}, m_cnt[0]);
      check({tag, "_cnt1"}, {27'd0, bus1.bit_count}, m_cnt[1]);
      check({tag, "_q0"}, exp_q0.size(), 0);
      check({tag, "_q1"}, exp_q1.size(), 0);
      check({tag, "_err0"}, err_seen0, 0);
      check({tag, "_err1"}, err_seen1, err_exp1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_dout0"}, {16'd0, bus0.data_out}, 0);
      check({tag, "_dout1"}, {16'd0, bus1.data_out}, 0);
      check({tag, "_flags0"}, {30'd0, bus0.data_valid, bus0.frame_err}, 0);
      check({tag, "_flags1"}, {30'd0, bus1.data_valid, bus1.frame_err}, 0);
      check({tag, "_bc0"}, {27'd0, bus0.bit_count}, 0);
      check({tag, "_bc1"}, {27'd0, bus1.bit_count}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] pat;
      rst  = 1'b1;
      cs   = 1'b1;
      sclk = 1'b0;
      sd   = 1'b0;
      model_clear();
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(2);

      // Single word, cs held low
      cs_down();
      send_word(16'hA5C3);
      end_test("t1");
      check("t1_dout0", {16'd0, bus0.data_out}, 32'hA5C3);
      check("t1_dout1", {16'd0, bus1.data_out}, 32'hA5C3);

      // Back-to-back words
      send_word(16'h1234);
      send_word(16'hFFFF);
      end_test("t2");
      check("t2_dout0", {16'd0, bus0.data_out}, 32'hFFFF);

      // cs released between every bit; u1 aborts after each bit
      pat = 16'h8001;
      cs_up();
      for (int i = DW - 1; i >= 0; i--) begin
         cs_down();
         send_bit(pat[i]);
         cs_up();
      end
      end_test("t3");
      check("t3_dout0", {16'd0, bus0.data_out}, 32'h8001);
      check("t3_dout1", {16'd0, bus1.data_out}, 32'hFFFF);

      // sclk activity with cs high
      for (int i = 0; i < 5; i++) begin
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
      end_test("t5");
      check("t5_bc0", {27'd0, bus0.bit_count}, 0);

      // 7 bits then cs raised, then a full word
      cs_down();
      pat = 16'hB600;
      for (int i = DW - 1; i >= DW - 7; i--) send_bit(pat[i]);
      tick(2);
      check("t4_bc1_partial", {27'd0, bus1.bit_count}, 7);
      cs_up();
      cs_down();
      send_word(16'h00FF);
      end_test("t4");
      check("t4_dout1", {16'd0, bus1.data_out}, 32'h00FF);

      // Reset mid-word, then a clean word
      pat = 16'h1FF0;
      for (int i = DW - 1; i >= DW - 9; i--) send_bit(pat[i]);
      tick(8);
      check("t6_bc1_partial", {27'd0, bus1.bit_count}, 9);
      check("t6_q0", exp_q0.size(), 0);
      rst = 1'b1;
      tick(1);
      check_zero("t6_rst");
      rst = 1'b0;
      model_clear();
      tick(4);
      send_word(16'h5A5A);
      end_test("t6");
      check("t6_dout0", {16'd0, bus0.data_out}, 32'h5A5A);
      check("t6_dout1", {16'd0, bus1.data_out}, 32'h5A5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI receive endpoint: takes cs/sclk/data from an SPI transmitter and assembles MSB-first 16-bit words.
- Delivers each completed word to the system clock domain as a one-cycle valid strobe.
- Bus signals are asynchronous to clk; they are synchronised and oversampled, never used as clocks.
- Sits at the far end of the serial link, feeding downstream register/consumer logic.

Parameters:
DATA_W, 16, word length in bits (MSB received first)
SYNC_STAGES, 2, flop stages on each of spi_cs, spi_sclk, spi_data (minimum 2)
CS_PER_WORD, 0, 0: cs low only gates sampling, and a partial word survives cs-high gaps; 1: cs rising mid-word aborts the word

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
spi_cs  input  1  chip select, active low, asynchronous
spi_sclk  input  1  serial clock, asynchronous; data sampled on its rising edge
spi_data  input  1  serial data line, asynchronous
data_out  output  DATA_W  last completed word; held until next completion
data_valid  output  1  one-cycle pulse, data_out newly updated
frame_err  output  1  one-cycle pulse, word aborted (CS_PER_WORD=1 only)
bit_count  output  $clog2(DATA_W)+1  bits captured in the current word (0..DATA_W-1)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high: sampled on the clk rising edge only.
- Reset values:
  - data_out=0, data_valid=0, frame_err=0, bit_count=0.
  - Shift register=0, all sync flops=idle level (cs=1, sclk=0, data=0).
  - State=IDLE.
- Reset mid-word discards partial data; no valid or err pulse is generated.
- Synchronisation: each input passes through SYNC_STAGES flops. A 1-flop history on synced sclk and cs forms edge detects.
- rise_evt = synced sclk 0->1 AND synced cs==0.
- rise_evt while synced cs==1 is ignored.
- Timing requirement: sclk high and low phases each ≥2 clk periods. Data must be stable ≥2 clk periods around the sclk rising edge.
- Sampling: on rise_evt, shift_reg <= {shift_reg[DATA_W-2:0], synced data}. The data sync path is length-matched to sclk, so no skew compensation is needed.
- FSM states are IDLE and SHIFT.
  - IDLE: bit_count==0. On rise_evt, capture bit, bit_count=1, go to SHIFT.
  - SHIFT: on rise_evt, capture bit, bit_count+1.
  - On the DATA_W-th bit: the next cycle shows data_out={shift_reg[DATA_W-2:0], bit} and data_valid=1; bit_count returns to 0 and the FSM to IDLE in that same update.
- Latency: data_valid is high the clk cycle after the cycle rise_evt is seen for the last bit. It lasts exactly one cycle.
- Back-to-back words: the first bit of the next word may arrive while data_valid is high and must be captured normally.
- CS_PER_WORD=1, cs rising (synced 0->1) in SHIFT:
  - frame_err pulses 1 cycle, bit_count=0, state=IDLE.
  - data_out is unchanged and no data_valid pulse is generated.
  - cs rising in IDLE produces no error.
- CS_PER_WORD=0: cs high only suppresses rise_evt. bit_count and shift_reg hold, and the word resumes on the next cs-low edge. frame_err stays 0.
- Simultaneous cs-rise and sclk-rise in the same cycle: rise_evt is computed from the current synced cs; cs high at sample means the bit is ignored.
- bit_count never reaches DATA_W; it wraps to 0 on completion.
- No handshake or backpressure: an unconsumed word is overwritten by the next completion.

Test Plan:
- cs low, 16 bits of 0xA5C3 MSB first, sclk = 4 clk high/4 low -> data_out=0xA5C3, data_valid high exactly 1 cycle, bit_count back to 0.
- Two words 0x1234 then 0xFFFF back-to-back, cs held low -> two single-cycle valid pulses; data_out=0x1234, then 0xFFFF.
- CS_PER_WORD=0, cs deasserted between every bit, sending 0x8001 -> bit_count holds across gaps, data_out=0x8001, frame_err never asserts.
- CS_PER_WORD=1, 7 bits sent then cs raised -> frame_err 1 cycle, no data_valid, bit_count=0; next full word 0x00FF received correctly.
- sclk toggled 5 times with cs high -> bit_count stays 0, no pulses.
- rst asserted after 9 bits -> next cycle all outputs 0; following full word 0x5A5A received with a single valid pulse.
